// File: rtl/win_check_pkg.sv
// Shared game definitions: difficulty levels, board edges and counter width.
package win_check_pkg;

    localparam int SIZE_EASY   = 8;
    localparam int SIZE_MEDIUM = 10;
    localparam int SIZE_HARD   = 16;
    localparam int CNT_W       = 9;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        EASY   = 2'd1,
        MEDIUM = 2'd2,
        HARD   = 2'd3
    } level_t;

    function automatic logic [4:0] level_size(level_t lvl);
        case (lvl)
            EASY:    return 5'(SIZE_EASY);
            MEDIUM:  return 5'(SIZE_MEDIUM);
            HARD:    return 5'(SIZE_HARD);
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/win_check_scan_cnt.sv
// Raster x/y counter over an n-by-n board; y is the inner (fast) index.
module board_scan_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic [4:0] n,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       last
);

    logic [3:0] n_m1;
    logic       y_end;

    assign n_m1  = 4'(n - 5'd1);
    assign y_end = (y == n_m1);
    assign last  = y_end && (x == n_m1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (run) begin
            if (y_end) begin
                y <= '0;
                x <= last ? 4'd0 : x + 4'd1;
            end else begin
                y <= y + 4'd1;
            end
        end
    end

endmodule

// File: rtl/win_check.sv
// Continuously scans the active board, counting safe and defused-safe cells,
// and flags a win once every safe cell is uncovered without touching a mine.
module win_check
    import win_check_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         level,
    input  logic               explode,
    input  logic [7:0][7:0]    mine_arr_easy,
    input  logic [9:0][9:0]    mine_arr_medium,
    input  logic [15:0][15:0]  mine_arr_hard,
    input  logic [7:0][7:0]    defuse_arr_easy,
    input  logic [9:0][9:0]    defuse_arr_medium,
    input  logic [15:0][15:0]  defuse_arr_hard,
    output logic [CNT_W-1:0]   defused_cnt,
    output logic [CNT_W-1:0]   safe_cnt,
    output logic               scan_done,
    output logic               win
);

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, HOLD} state_t;

    state_t             state, state_nxt;
    level_t             lvl_q;
    logic [CNT_W-1:0]   safe_acc, def_acc;
    logic               mine_hit;
    logic [3:0]         x, y;
    logic               last;
    logic               mine_c, def_c;
    logic               start, scan_en, do_eval, abort, level_chg, win_cond;

    board_scan_cnt u_scan (
        .clk   (clk),
        .rst   (rst),
        .run   (scan_en),
        .clear (start | do_eval),
        .n     (level_size(lvl_q)),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    always_comb begin
        mine_c = 1'b0;
        def_c  = 1'b0;
        case (lvl_q)
            EASY: begin
                mine_c = mine_arr_easy[x[2:0]][y[2:0]];
                def_c  = defuse_arr_easy[x[2:0]][y[2:0]];
            end
            MEDIUM: begin
                mine_c = mine_arr_medium[x][y];
                def_c  = defuse_arr_medium[x][y];
            end
            HARD: begin
                mine_c = mine_arr_hard[x][y];
                def_c  = defuse_arr_hard[x][y];
            end
            default: ;
        endcase
    end

    // An empty (all-mine) board must never count as won.
    assign win_cond = (def_acc == safe_acc) && (safe_acc != '0) && !mine_hit;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        scan_en   = 1'b0;
        do_eval   = 1'b0;
        abort     = 1'b0;
        level_chg = (state != IDLE) && (level_t'(level) != lvl_q);
        if (explode) begin
            state_nxt = IDLE;
        end else if (level_chg) begin
            state_nxt = IDLE;
            abort     = 1'b1;
        end else begin
            case (state)
                IDLE: if (level != 2'd0) begin
                    state_nxt = SCAN;
                    start     = 1'b1;
                end
                SCAN: begin
                    scan_en = 1'b1;
                    if (last) state_nxt = EVAL;
                end
                EVAL: begin
                    do_eval   = 1'b1;
                    state_nxt = win_cond ? HOLD : SCAN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q       <= NONE;
            safe_acc    <= '0;
            def_acc     <= '0;
            mine_hit    <= 1'b0;
            defused_cnt <= '0;
            safe_cnt    <= '0;
            scan_done   <= 1'b0;
            win         <= 1'b0;
        end else begin
            scan_done <= do_eval;
            if (start) lvl_q <= level_t'(level);
            if (start || do_eval) begin
                safe_acc <= '0;
                def_acc  <= '0;
                mine_hit <= 1'b0;
            end else if (scan_en) begin
                safe_acc <= safe_acc + CNT_W'(!mine_c);
                def_acc  <= def_acc + CNT_W'(def_c && !mine_c);
                mine_hit <= mine_hit | (def_c & mine_c);
            end
            // Explode keeps the last counts visible; a level change wipes them.
            if (explode) begin
                win <= 1'b0;
            end else if (abort) begin
                win         <= 1'b0;
                defused_cnt <= '0;
                safe_cnt    <= '0;
            end else if (do_eval) begin
                defused_cnt <= def_acc;
                safe_cnt    <= safe_acc;
                win         <= win_cond;
            end else if (state == IDLE) begin
                win <= 1'b0;
            end
        end
    end

endmodule
